// File: rtl/batchnorm_seq_ctrl.sv
// batchnorm_seq_ctrl: per-channel BN parameter fetch, pixel issue and drain sequencer.
// Define BN_PARAM_PREFETCH_EN to prefetch the next channel's parameters into shadow registers.
module batchnorm_seq_ctrl #(
  parameter int IMG_H  = 256,
  parameter int IMG_W  = 256,
  parameter int NUM_CH = 64,
  parameter int PIX_AW = 16,
  parameter int CH_AW  = 6,
  parameter int OUT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              param_rd_en_o,
  output logic [CH_AW-1:0]  param_rd_addr_o,
  input  logic [7:0]        param_mean_i,
  input  logic [7:0]        param_var_i,
  output logic [7:0]        bn_mean_o,
  output logic [7:0]        bn_var_o,
  output logic              bn_param_load_o,
  output logic              pix_valid_o,
  input  logic              pix_ready_i,
  output logic [PIX_AW-1:0] pix_addr_o,
  output logic [CH_AW-1:0]  pix_ch_o,
  input  logic              dp_out_valid_i
);
  localparam logic [PIX_AW-1:0] LAST_PIX = PIX_AW'(IMG_H * IMG_W - 1);
  localparam logic [CH_AW-1:0]  LAST_CH  = CH_AW'(NUM_CH - 1);
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, STREAM, DRAIN, DONE} state_t;
  state_t            state_q, state_d;
  logic [CH_AW-1:0]  ch_q, ch_d;
  logic [PIX_AW-1:0] pix_q, pix_d;
  logic [OUT_W-1:0]  out_q, out_d;
  logic [7:0]        mean_q, mean_d, var_q, var_d;
  logic              err_q, err_d, load_q, load_d;
  logic              acc, xfer, ret_ok, pf_rd;
  assign acc    = state_q == IDLE && start_i;
  assign xfer   = pix_valid_o && pix_ready_i;
  assign ret_ok = dp_out_valid_i && out_q != '0;
`ifdef BN_PARAM_PREFETCH_EN
  logic       pf_cap_q;
  logic [7:0] sh_mean_q, sh_var_q;
  // Next channel's parameters are requested on the first cycle of each stream.
  assign pf_rd = state_q == STREAM && load_q && ch_q != LAST_CH;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pf_cap_q  <= 1'b0;
      sh_mean_q <= '0;
      sh_var_q  <= '0;
    end else begin
      pf_cap_q <= pf_rd;
      if (pf_cap_q) begin
        sh_mean_q <= param_mean_i;
        sh_var_q  <= param_var_i;
      end
    end
`else
  assign pf_rd = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    pix_d   = pix_q;
    mean_d  = mean_q;
    var_d   = var_q;
    load_d  = 1'b0;
    out_d   = acc ? '0 : out_q + OUT_W'(xfer) - OUT_W'(ret_ok);
    err_d   = acc ? 1'b0 : err_q | (dp_out_valid_i && out_q == '0);
    unique case (state_q)
      IDLE: if (start_i) begin
        state_d = FETCH;
        ch_d    = '0;
        pix_d   = '0;
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        state_d = STREAM;
        mean_d  = param_mean_i;
        var_d   = param_var_i;
        load_d  = 1'b1;
      end
      STREAM: if (xfer) begin
        pix_d   = pix_q == LAST_PIX ? '0 : pix_q + 1'b1;
        state_d = pix_q == LAST_PIX ? DRAIN : STREAM;
      end
      DRAIN: if (out_q == '0) begin
        if (ch_q == LAST_CH) state_d = DONE;
        else begin
          ch_d = ch_q + 1'b1;
`ifdef BN_PARAM_PREFETCH_EN
          state_d = STREAM;
          mean_d  = sh_mean_q;
          var_d   = sh_var_q;
          load_d  = 1'b1;
`else
          state_d = FETCH;
`endif
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      ch_q    <= '0;
      pix_q   <= '0;
      out_q   <= '0;
      mean_q  <= '0;
      var_q   <= '0;
      err_q   <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      pix_q   <= pix_d;
      out_q   <= out_d;
      mean_q  <= mean_d;
      var_q   <= var_d;
      err_q   <= err_d;
      load_q  <= load_d;
    end
  // Issue is withheld while the outstanding counter is saturated.
  assign pix_valid_o     = state_q == STREAM && !(&out_q);
  assign busy_o          = state_q != IDLE;
  assign done_o          = state_q == DONE;
  assign err_o           = err_q;
  assign param_rd_en_o   = state_q == FETCH || pf_rd;
  assign param_rd_addr_o = pf_rd ? ch_q + 1'b1 : ch_q;
  assign bn_mean_o       = mean_q;
  assign bn_var_o        = var_q;
  assign bn_param_load_o = load_q;
  assign pix_addr_o      = pix_q;
  assign pix_ch_o        = ch_q;
endmodule

// File: tb/tb_batchnorm_seq_ctrl.sv
// tb_batchnorm_seq_ctrl: randomized bench with a queue-based datapath and parameter RAM model.
module tb_batchnorm_seq_ctrl;
  localparam int H = 2, W = 2, NC = 2, PAW = 16, CAW = 6, OW = 2;
  localparam int NPIX = H * W, TOTAL = NPIX * NC, MAXO = (1 << OW) - 1;
`ifdef BN_PARAM_PREFETCH_EN
  localparam int GAP = 2;
`else
  localparam int GAP = 4;
`endif
  logic clk = 0, rst = 1, start_i = 0, pix_ready_i = 0, dp_out_valid_i = 0;
  logic [7:0] param_mean_i = 0, param_var_i = 0;
  logic busy_o, done_o, err_o, param_rd_en_o, bn_param_load_o, pix_valid_o;
  logic [CAW-1:0] param_rd_addr_o, pix_ch_o;
  logic [7:0] bn_mean_o, bn_var_o;
  logic [PAW-1:0] pix_addr_o;
  always #5 clk = ~clk;
  batchnorm_seq_ctrl #(.IMG_H(H), .IMG_W(W), .NUM_CH(NC), .PIX_AW(PAW), .CH_AW(CAW), .OUT_W(OW)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .param_rd_en_o(param_rd_en_o), .param_rd_addr_o(param_rd_addr_o),
    .param_mean_i(param_mean_i), .param_var_i(param_var_i),
    .bn_mean_o(bn_mean_o), .bn_var_o(bn_var_o), .bn_param_load_o(bn_param_load_o),
    .pix_valid_o(pix_valid_o), .pix_ready_i(pix_ready_i), .pix_addr_o(pix_addr_o),
    .pix_ch_o(pix_ch_o), .dp_out_valid_i(dp_out_valid_i));
  int n_chk = 0, n_fail = 0;
  int cyc = 0, exp_idx, outst, done_cnt, load_cnt, start_cyc = -100, last_ret, last_due, rmode, dmode;
  int dueq[$];
  logic [7:0] mean_tab [NC], var_tab [NC];
  logic pend = 0, prev_stall = 0, prev_valid = 0;
  logic [CAW-1:0] pend_a = 0, prev_ch = 0;
  logic [PAW-1:0] prev_addr = 0;
  logic [7:0] prev_mean = 0, prev_var = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask
  task automatic tick(input logic s, input logic f);
    logic due;
    int d, ch;
    @(negedge clk);
    cyc++;
    start_i = s;
    pix_ready_i = rmode == 0 ? 1'b1 : rmode == 1 ? cyc[0] : 1'($urandom_range(0, 1));
    due = dueq.size() > 0 && dueq[0] == cyc;
    dp_out_valid_i = f || due;
    param_mean_i = pend && pend_a < NC ? mean_tab[pend_a] : 8'($urandom);
    param_var_i = pend && pend_a < NC ? var_tab[pend_a] : 8'($urandom);
    pend = param_rd_en_o;
    pend_a = param_rd_addr_o;
    ch = exp_idx / NPIX;
    if (s && !busy_o) start_cyc = cyc;
    if (cyc == start_cyc + 1) check("err_clr", err_o, 0);
    if (bn_mean_o !== prev_mean || bn_var_o !== prev_var) check("param_quiet", outst, 0);
    if (outst == MAXO) check("sat_valid", pix_valid_o, 0);
    if (prev_stall) check("hold", {pix_ch_o, pix_addr_o}, {prev_ch, prev_addr});
    if (pix_valid_o && !prev_valid && exp_idx == 0) check("first_valid", cyc - start_cyc, 3);
    if (pix_valid_o && !prev_valid && exp_idx > 0 && exp_idx % NPIX == 0) check("gap", cyc - last_ret, GAP);
    if (bn_param_load_o) begin
      load_cnt++;
      check("load_param", {bn_mean_o, bn_var_o}, {mean_tab[ch % NC], var_tab[ch % NC]});
`ifdef BN_PARAM_PREFETCH_EN
      if (ch < NC - 1) check("pf_rd", {param_rd_en_o, param_rd_addr_o}, {1'b1, CAW'(ch + 1)});
`endif
    end
    if (done_o) begin
      done_cnt++;
      check("done_lat", cyc - last_ret, 2);
      check("done_idx", exp_idx, TOTAL);
    end
    if (due) begin
      void'(dueq.pop_front());
      outst--;
      if (outst == 0) last_ret = cyc;
    end
    if (pix_valid_o && pix_ready_i) begin
      check("pix_addr", pix_addr_o, exp_idx % NPIX);
      check("pix_ch", pix_ch_o, ch);
      check("bn_param", {bn_mean_o, bn_var_o}, {mean_tab[ch % NC], var_tab[ch % NC]});
      d = dmode == 0 ? 2 : dmode == 1 ? 10 : int'($urandom_range(1, 5));
      last_due = cyc + d > last_due + 1 ? cyc + d : last_due + 1;
      dueq.push_back(last_due);
      outst++;
      exp_idx++;
    end
    prev_stall = pix_valid_o && !pix_ready_i;
    prev_valid = pix_valid_o;
    prev_addr = pix_addr_o;
    prev_ch = pix_ch_o;
    prev_mean = bn_mean_o;
    prev_var = bn_var_o;
  endtask
  task automatic run_layer(input int rm, input int dm, input int abort_idx, input int sb);
    rmode = rm;
    dmode = dm;
    exp_idx = 0; outst = 0; done_cnt = 0; load_cnt = 0; last_ret = -100; last_due = 0;
    dueq.delete();
    for (int c = 0; c < NC; c++) begin
      mean_tab[c] = 8'($urandom);
      var_tab[c] = 8'($urandom);
    end
    tick(1, 0);
    for (int i = 0; i < 2000 && done_cnt == 0 && !(abort_idx > 0 && exp_idx >= abort_idx); i++)
      tick(i == sb, 0);
    if (abort_idx == 0) begin
      repeat (6) tick(0, 0);
      check("done_cnt", done_cnt, 1);
      check("loads", load_cnt, NC);
      check("issued", exp_idx, TOTAL);
      check("err_end", err_o, 0);
      check("busy_end", busy_o, 0);
    end
  endtask
  initial begin
    rmode = 0; dmode = 0; exp_idx = 0; outst = 0; done_cnt = 0; load_cnt = 0; last_ret = -100; last_due = 0;
    #3;
    check("rst_ctrl", {busy_o, done_o, err_o, param_rd_en_o, bn_param_load_o, pix_valid_o}, 0);
    check("rst_data", {param_rd_addr_o, bn_mean_o, bn_var_o}, 0);
    check("rst_pix", {pix_ch_o, pix_addr_o}, 0);
    @(negedge clk);
    rst = 0;
    run_layer(0, 0, 0, -1);
    run_layer(1, 0, 0, -1);
    run_layer(0, 1, 0, -1);
    run_layer(2, 2, 0, 4);
    tick(0, 1);
    tick(0, 0);
    check("err_set", err_o, 1);
    repeat (3) tick(0, 0);
    check("err_hold", err_o, 1);
    run_layer(2, 2, 0, -1);
    run_layer(2, 2, NPIX + 1, -1);
    #2 rst = 1;
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_valid", pix_valid_o, 0);
    check("rst_no_done", done_cnt, 0);
    @(negedge clk);
    rst = 0;
    dp_out_valid_i = 0;
    dueq.delete();
    outst = 0; pend = 0; prev_stall = 0; prev_valid = 0; prev_mean = 0; prev_var = 0;
    run_layer(0, 0, 0, -1);
    for (int k = 0; k < 4; k++) run_layer(int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 0, -1);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/batchnorm_seq_ctrl.md
# batchnorm_seq_ctrl

Sequencer that drives the batch-normalization datapath over a full feature map, one channel at a time. It fetches each channel's mean/variance from the parameter memory and presents them to the datapath. It then walks every pixel address of that channel through a valid/ready issue port and drains in-flight results before the parameters change. It sits between the layer scheduler (start/done) and the BN datapath with its parameter RAM.

## Interface
Parameters:
- IMG_H, 256, feature-map rows
- IMG_W, 256, feature-map columns
- NUM_CH, 64, channels
- PIX_AW, 16, pixel address width (≥ clog2(IMG_H*IMG_W))
- CH_AW, 6, channel index width (≥ clog2(NUM_CH))
- OUT_W, 4, outstanding-pixel counter width

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  start pulse; honoured only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse at end of last channel
- err  out  1  sticky: retire seen with zero outstanding; cleared by rst or accepted start
- param_rd_en  out  1  parameter RAM read strobe
- param_rd_addr  out  CH_AW  channel to read
- param_mean  in  8  mean, valid the cycle after param_rd_en
- param_var  in  8  variance, valid the cycle after param_rd_en
- bn_mean  out  8  mean applied by datapath
- bn_var  out  8  variance applied by datapath
- bn_param_load  out  1  one-cycle pulse when bn_mean/bn_var take new values
- pix_valid  out  1  pixel issue valid
- pix_ready  in  1  datapath accepts issue
- pix_addr  out  PIX_AW  row*IMG_W+col of issued pixel
- pix_ch  out  CH_AW  channel of issued pixel
- dp_out_valid  in  1  one result retired by datapath

## Operation
- States: IDLE, FETCH, LOAD, STREAM, DRAIN, DONE.
- IDLE: start=1 → FETCH; ch=0, pix_addr=0, outstanding=0, err=0.
- FETCH (1 cycle): param_rd_en=1, param_rd_addr=ch → LOAD.
- LOAD (1 cycle): bn_mean/bn_var ← param_mean/param_var at exit edge → STREAM. bn_param_load is high during the first STREAM cycle.
- STREAM: pix_valid=1, pix_ch=ch. A transfer occurs when pix_valid&pix_ready.
  - On each transfer, pix_addr increments (row-major, col fastest).
  - The transfer with pix_addr=IMG_H*IMG_W-1 → DRAIN, with pix_addr reset to 0.
  - pix_addr/pix_ch are held stable while pix_valid&!pix_ready.
- DRAIN: pix_valid=0; wait for outstanding==0, including the cycle it reaches 0. Then:
  - ch==NUM_CH-1 → DONE;
  - otherwise ch+1 → FETCH.
- DONE (1 cycle): done=1 → IDLE.
- Outstanding counter:
  - +1 on transfer, −1 on dp_out_valid; unchanged when both occur in the same cycle.
  - dp_out_valid with outstanding==0: ignored and err set.
  - Counter saturates at 2^OUT_W−1. While saturated, pix_valid is forced 0.
- start while busy: ignored. dp_out_valid in IDLE: sets err.
- Parameters never change while outstanding≠0.

## Timing
- Reset values: busy=0, done=0, err=0, param_rd_en=0, param_rd_addr=0, bn_mean=0, bn_var=0, bn_param_load=0, pix_valid=0, pix_addr=0, pix_ch=0, state=IDLE.
- rst mid-operation: immediate return to IDLE, all counters cleared; no done pulse.
- start sampled at edge 0 → FETCH in cycle 1, LOAD in cycle 2, first pix_valid in cycle 3.
- Throughput: 1 pixel/cycle in STREAM with pix_ready=1.
- Channel-boundary overhead (last retire → next first issue): 3 cycles (DRAIN exit, FETCH, LOAD).
- done rises 2 cycles after the final retire: DRAIN sees 0, then DONE.

## Configuration
- BN_PARAM_PREFETCH_EN defined:
  - During the first STREAM cycle of channel ch<NUM_CH-1, the block issues param_rd_en with addr ch+1 and captures the result into shadow registers the next cycle.
  - DRAIN exit goes straight to STREAM, loading bn_mean/bn_var from the shadow registers with a bn_param_load pulse.
  - Channel-boundary overhead: 1 cycle. The FETCH/LOAD path is used only for channel 0.
- Not defined: no shadow registers; every channel passes through FETCH and LOAD as described above.

## Test plan
- IMG_H=IMG_W=2, NUM_CH=2, pix_ready=1, retire 2 cycles after issue → pix_addr 0,1,2,3 with pix_ch=0, then 0,1,2,3 with pix_ch=1; exactly one done; err=0; first pix_valid in cycle 3 after start.
- Same config, pix_ready toggling 1/0 each cycle → pix_addr/pix_ch held stable during stalls; 8 transfers total; bn_param_load pulses exactly twice.
- Datapath delays retires 10 cycles → bn_mean does not change until outstanding=0; next FETCH follows only after DRAIN.
- Assert rst during channel 1 STREAM, then start again → busy=0 immediately; restart begins at ch=0, pix_addr=0 with no done.
- start pulsed while busy, and dp_out_valid with outstanding=0 → start ignored; err=1 and held until next accepted start.
- BN_PARAM_PREFETCH_EN, mean table {10,20} → param_rd_addr=1 read in first STREAM cycle of ch0; bn_mean=20 one cycle after ch0 drain completes; boundary overhead 1 cycle.
